// File: rtl/twiddle_cmpy_if.sv
// twiddle_cmpy_if
//   Bundles the sample/coefficient/aux inputs and the product/aux outputs of
//   the twiddle multiplier stage.
//   Signals:
//     i_ce    clock enable for the whole stage
//     i_left  sample, real in the upper half, imaginary in the lower half
//     i_coef  twiddle, real in the upper half, imaginary in the lower half
//     i_aux   sync tag travelling with the sample
//     o_out   rounded complex product, real upper / imaginary lower
//     o_aux   i_aux delayed to line up with o_out
//   Modports: master drives the inputs (upstream / bench),
//             slave is the multiplier stage itself.
interface twiddle_cmpy_if #(
    parameter int IWIDTH = 16,
    parameter int CWIDTH = 16,
    parameter int OWIDTH = 17
);
    logic                  i_ce;
    logic [2*IWIDTH-1:0]   i_left;
    logic [2*CWIDTH-1:0]   i_coef;
    logic                  i_aux;
    logic [2*OWIDTH-1:0]   o_out;
    logic                  o_aux;

    modport master (
        output i_ce, i_left, i_coef, i_aux,
        input  o_out, o_aux
    );

    modport slave (
        input  i_ce, i_left, i_coef, i_aux,
        output o_out, o_aux
    );
endinterface

// File: rtl/twiddle_cmpy.sv
// twiddle_cmpy
//   Complex twiddle multiplier for the FFT butterfly datapath:
//   o_out = round((left * coef) << SHIFT) selected down to OWIDTH bits per
//   component, convergent rounding, two's-complement wrap on overflow.
//   Latency LAT = LMPY + 2 enabled cycles for both data and aux.
//   Ports:
//     i_clk       system clock, rising edge
//     i_areset_n  asynchronous active-low reset
//     bus         twiddle_cmpy_if.slave (i_ce, i_left, i_coef, i_aux,
//                 o_out, o_aux)
//   Also contains longbimpy, the signed shift-add pipelined multiplier.

// longbimpy
//   Signed pipelined shift-add multiplier, full-precision AW+BW bit product.
//   The narrower operand is consumed two bits per stage; latency is
//   (min(AW,BW)+1)/2 + 2 enabled cycles (input register, shift-add stages,
//   output register). No reset: contents are pure data.
//   Ports: i_clk, i_ce, i_a (AW signed), i_b (BW signed), o_p (product).
module longbimpy #(
    parameter int AW = 16,
    parameter int BW = 16
) (
    input  logic                    i_clk,
    input  logic                    i_ce,
    input  logic signed [AW-1:0]    i_a,
    input  logic signed [BW-1:0]    i_b,
    output logic signed [AW+BW-1:0] o_p
);
    localparam int PW   = AW + BW;
    localparam int SW   = (AW < BW) ? AW : BW;
    localparam int NSTG = (SW + 1) / 2;
    localparam int YW   = 2 * NSTG;

    logic signed [PW-1:0] x_in;
    logic signed [YW-1:0] y_in;

    // The narrower operand becomes the bit-serial multiplier; it is
    // sign-extended to an even width so every stage eats exactly two bits.
    generate
        if (AW < BW) begin : g_swap
            always_comb begin
                x_in = PW'(i_b);
                y_in = YW'(i_a);
            end
        end else begin : g_noswap
            always_comb begin
                x_in = PW'(i_a);
                y_in = YW'(i_b);
            end
        end
    endgenerate

    logic signed [PW-1:0] x_q   [0:NSTG];
    logic signed [YW-1:0] y_q   [0:NSTG];
    logic signed [PW-1:0] acc_q [0:NSTG];
    logic signed [PW-1:0] p_q;

    always_ff @(posedge i_clk) begin
        if (i_ce) begin
            x_q[0]   <= x_in;
            y_q[0]   <= y_in;
            acc_q[0] <= '0;
            for (int k = 0; k < NSTG; k++) begin
                x_q[k+1] <= x_q[k] <<< 2;
                y_q[k+1] <= y_q[k] >>> 2;
                // In the final stage bit 1 is the sign bit of the multiplier,
                // which carries negative weight.
                if (k == NSTG - 1)
                    acc_q[k+1] <= acc_q[k]
                                + (y_q[k][0] ? x_q[k] : '0)
                                - (y_q[k][1] ? (x_q[k] <<< 1) : '0);
                else
                    acc_q[k+1] <= acc_q[k]
                                + (y_q[k][0] ? x_q[k] : '0)
                                + (y_q[k][1] ? (x_q[k] <<< 1) : '0);
            end
            p_q <= acc_q[NSTG];
        end
    end

    assign o_p = p_q;
endmodule

module twiddle_cmpy #(
    parameter int IWIDTH = 16,
    parameter int CWIDTH = 16,
    parameter int OWIDTH = 17,
    parameter int SHIFT  = 2
) (
    input  logic           i_clk,
    input  logic           i_areset_n,
    twiddle_cmpy_if.slave  bus
);
    localparam int MW   = IWIDTH + CWIDTH;
    localparam int PW   = MW + 1;
    localparam int D    = PW - SHIFT - OWIDTH;
    localparam int TW   = PW - D;
    localparam int LMPY = (((IWIDTH < CWIDTH) ? IWIDTH : CWIDTH) + 1) / 2 + 2;
    localparam int LAT  = LMPY + 2;

    generate
        if (D < 1) begin : g_bad_d
            $error("twiddle_cmpy: PW - SHIFT - OWIDTH must be at least 1");
        end
    endgenerate

    localparam logic [D-1:0] HALF = D'(1) << (D - 1);

    // Operand routing: product 0 = ar*cr, 1 = ai*ci, 2 = ar*ci, 3 = ai*cr.
    logic signed [IWIDTH-1:0] a_sel [0:3];
    logic signed [CWIDTH-1:0] c_sel [0:3];
    logic signed [MW-1:0]     prod  [0:3];

    always_comb begin
        a_sel[0] = bus.i_left[2*IWIDTH-1:IWIDTH];
        a_sel[1] = bus.i_left[IWIDTH-1:0];
        a_sel[2] = bus.i_left[2*IWIDTH-1:IWIDTH];
        a_sel[3] = bus.i_left[IWIDTH-1:0];
        c_sel[0] = bus.i_coef[2*CWIDTH-1:CWIDTH];
        c_sel[1] = bus.i_coef[CWIDTH-1:0];
        c_sel[2] = bus.i_coef[CWIDTH-1:0];
        c_sel[3] = bus.i_coef[2*CWIDTH-1:CWIDTH];
    end

    genvar gi;
    generate
        for (gi = 0; gi < 4; gi++) begin : g_mpy
            longbimpy #(
                .AW (IWIDTH),
                .BW (CWIDTH)
            ) u_mpy (
                .i_clk (i_clk),
                .i_ce  (bus.i_ce),
                .i_a   (a_sel[gi]),
                .i_b   (c_sel[gi]),
                .o_p   (prod[gi])
            );
        end
    endgenerate

    // Add stage: one extra bit makes the sums overflow-free.
    logic signed [PW-1:0] rsum_q, isum_q, rsum_d, isum_d;

    always_comb begin
        rsum_d = PW'(prod[0]) - PW'(prod[1]);
        isum_d = PW'(prod[2]) + PW'(prod[3]);
    end

    // Round half to even on sum / 2^D, then keep the low OWIDTH bits.
    // trunc is floor(sum / 2^D) and frac is the non-negative remainder,
    // which holds for negative sums as well.
    function automatic logic [OWIDTH-1:0] conv_round(input logic signed [PW-1:0] s);
        logic [TW-1:0] trunc;
        logic [D-1:0]  frac;
        logic          up;
        logic [TW-1:0] r;
        trunc = s[PW-1:D];
        frac  = s[D-1:0];
        up    = (frac > HALF) || ((frac == HALF) && trunc[0]);
        r     = trunc + TW'(up);
        return r[OWIDTH-1:0];
    endfunction

    logic [2*OWIDTH-1:0] out_q, out_d;
    logic [LAT-1:0]      aux_q, aux_d;

    always_comb begin
        out_d = {conv_round(rsum_q), conv_round(isum_q)};
        aux_d = {aux_q[LAT-2:0], bus.i_aux};
    end

    always_ff @(posedge i_clk or negedge i_areset_n) begin
        if (!i_areset_n) begin
            rsum_q <= '0;
            isum_q <= '0;
            out_q  <= '0;
            aux_q  <= '0;
        end else if (bus.i_ce) begin
            rsum_q <= rsum_d;
            isum_q <= isum_d;
            out_q  <= out_d;
            aux_q  <= aux_d;
        end
    end

    assign bus.o_out = out_q;
    assign bus.o_aux = aux_q[LAT-1];
endmodule

// File: tb/tb_twiddle_cmpy.sv
// tb_twiddle_cmpy
//   Scoreboard bench for twiddle_cmpy. The stimulus process computes each
//   expected product with plain integer arithmetic and queues it; the
//   monitor process counts enabled clock edges and pops/compares once the
//   pipeline latency has elapsed, and checks that outputs hold while i_ce=0.
module tb_twiddle_cmpy;
    localparam int IW   = 16;
    localparam int CW   = 16;
    localparam int OW   = 17;
    localparam int SH   = 2;
    localparam int PW   = IW + CW + 1;
    localparam int D    = PW - SH - OW;
    localparam int LMPY = (((IW < CW) ? IW : CW) + 1) / 2 + 2;
    localparam int LAT  = LMPY + 2;

    typedef struct {
        logic [2*OW-1:0] out;
        logic            aux;
    } exp_t;

    exp_t sb_q[$];

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    int   tests = 0;
    int   fails = 0;
    int   n_out = 0;

    always #5 clk = ~clk;

    twiddle_cmpy_if #(.IWIDTH(IW), .CWIDTH(CW), .OWIDTH(OW)) bus ();

    twiddle_cmpy #(
        .IWIDTH (IW),
        .CWIDTH (CW),
        .OWIDTH (OW),
        .SHIFT  (SH)
    ) dut (
        .i_clk      (clk),
        .i_areset_n (rst_n),
        .bus        (bus)
    );

    // Reference: exact value divided by 2^D, ties to even, wrapped to OW bits.
    function automatic logic [OW-1:0] ref_round(input longint s);
        longint q, r, half;
        half = longint'(1) <<< (D - 1);
        q = s >>> D;
        r = s - (q <<< D);
        if (r > half || (r == half && q[0]))
            q = q + 1;
        return OW'(q);
    endfunction

    function automatic logic [2*OW-1:0] ref_cmul(input int lr, input int li,
                                                 input int cr, input int ci);
        longint re, im;
        re = longint'(lr) * cr - longint'(li) * ci;
        im = longint'(lr) * ci + longint'(li) * cr;
        return {ref_round(re), ref_round(im)};
    endfunction

    function automatic int rnd16();
        int sel;
        sel = int'($urandom_range(0, 9));
        if (sel == 0) return -32768;
        if (sel == 1) return 32767;
        return int'($urandom_range(0, 65535)) - 32768;
    endfunction

    task automatic drive(input bit ce, input int lr, input int li,
                         input int cr, input int ci, input bit aux);
        exp_t e;
        @(negedge clk);
        bus.i_ce   = ce;
        bus.i_left = {IW'(lr), IW'(li)};
        bus.i_coef = {CW'(cr), CW'(ci)};
        bus.i_aux  = aux;
        if (ce && rst_n) begin
            e.out = ref_cmul(lr, li, cr, ci);
            e.aux = aux;
            sb_q.push_back(e);
        end
    endtask

    task automatic check_reset_outputs(input string name);
        tests++;
        if (bus.o_out !== '0) begin
            fails++;
            $display("FAIL %s_out: got %h required 0", name, bus.o_out);
        end
        tests++;
        if (bus.o_aux !== 1'b0) begin
            fails++;
            $display("FAIL %s_aux: got %b required 0", name, bus.o_aux);
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        bus.i_ce = 1'b0;
        rst_n    = 1'b0;
        sb_q.delete();
        #1;
        check_reset_outputs("reset_mid");
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
    endtask

    // Monitor: after each enabled edge the output belongs to the sample taken
    // LAT-1 enabled edges earlier; before that only o_aux=0 is guaranteed.
    initial begin : monitor
        bit              ce_s, rst_s;
        int              en_cnt;
        logic [2*OW-1:0] prev_out;
        logic            prev_aux;
        exp_t            e;
        en_cnt   = 0;
        prev_out = '0;
        prev_aux = 1'b0;
        forever begin
            @(posedge clk);
            ce_s  = bus.i_ce;
            rst_s = rst_n;
            #1;
            if (!rst_s || !rst_n) begin
                en_cnt   = 0;
                prev_out = '0;
                prev_aux = 1'b0;
            end else if (ce_s) begin
                en_cnt++;
                if (en_cnt >= LAT) begin
                    if (sb_q.size() == 0) begin
                        tests++;
                        fails++;
                        $display("FAIL sb_empty: got output with 0 queued entries, required at least 1");
                    end else begin
                        e = sb_q.pop_front();
                        n_out++;
                        tests++;
                        if (bus.o_out !== e.out) begin
                            fails++;
                            $display("FAIL out_data #%0d: got re=%0d im=%0d, required re=%0d im=%0d",
                                     n_out, $signed(bus.o_out[2*OW-1:OW]), $signed(bus.o_out[OW-1:0]),
                                     $signed(e.out[2*OW-1:OW]), $signed(e.out[OW-1:0]));
                        end
                        tests++;
                        if (bus.o_aux !== e.aux) begin
                            fails++;
                            $display("FAIL out_aux #%0d: got %b required %b", n_out, bus.o_aux, e.aux);
                        end
                        $display("[TB] out %0d re=%0d im=%0d aux=%b", n_out,
                                 $signed(bus.o_out[2*OW-1:OW]), $signed(bus.o_out[OW-1:0]), bus.o_aux);
                    end
                end else begin
                    tests++;
                    if (bus.o_aux !== 1'b0) begin
                        fails++;
                        $display("FAIL aux_warmup edge %0d: got %b required 0", en_cnt, bus.o_aux);
                    end
                end
                prev_out = bus.o_out;
                prev_aux = bus.o_aux;
            end else begin
                tests++;
                if (bus.o_out !== prev_out || bus.o_aux !== prev_aux) begin
                    fails++;
                    $display("FAIL hold_ce0: got out=%h aux=%b required out=%h aux=%b",
                             bus.o_out, bus.o_aux, prev_out, prev_aux);
                end
            end
        end
    end

    initial begin : watchdog
        #2000000;
        $display("FAIL watchdog: simulation time limit reached, got no finish, required finish");
        $fatal(1, "watchdog");
    end

    initial begin : stim
        int n;
        int rvals [5];
        bit ce;
        rvals = '{1, 3, 5, -3, 7};
        bus.i_ce   = 1'b0;
        bus.i_left = '0;
        bus.i_coef = '0;
        bus.i_aux  = 1'b0;
        #1;
        check_reset_outputs("reset_init");
        repeat (3) @(negedge clk);
        rst_n = 1'b1;

        // Directed cases: identity, complex, rounding ties, wrap.
        drive(1, 1000, 0, 16384, 0, 1);
        drive(1, 1000, 1000, 16384, 16384, 0);
        for (int i = 0; i < 5; i++)
            drive(1, rvals[i], 0, 8192, 0, 0);
        drive(1, -32768, -32768, -32768, 32767, 1);
        drive(0, 0, 0, 0, 0, 0);
        drive(1, -32768, 0, -32768, 0, 0);

        // Mid-stream reset, then the first aux after release must line up.
        for (int i = 0; i < 20; i++)
            drive(1, rnd16(), rnd16(), rnd16(), rnd16(), i == 0);
        do_reset();
        drive(1, rnd16(), rnd16(), rnd16(), rnd16(), 1);
        for (int i = 0; i < 20; i++)
            drive(1, rnd16(), rnd16(), rnd16(), rnd16(), 0);

        // Random data with roughly 30% clock-enable gaps.
        n = 0;
        while (n < 1000) begin
            ce = ($urandom_range(0, 99) >= 30);
            drive(ce, rnd16(), rnd16(), rnd16(), rnd16(), 1'($urandom_range(0, 1)));
            if (ce) n++;
        end

        // Push the last real samples out of the pipeline.
        repeat (LAT + 2) drive(1, 0, 0, 0, 0, 0);
        drive(0, 0, 0, 0, 0, 0);
        drive(0, 0, 0, 0, 0, 0);

        tests++;
        if (sb_q.size() != LAT - 1) begin
            fails++;
            $display("FAIL drain: got %0d queued entries, required %0d", sb_q.size(), LAT - 1);
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
